mcu: RTL and testbench

Single-cycle RV32I microcontroller top: program counter, instruction ROM, 32×32 register file, ALU, immediate generator, control decoder and a word-organised data RAM in one module hierarchy. Each clock it fetches, decodes, executes and retires exactly one instruction. Benches preload the instruction ROM and register file through hierarchical paths and observe results in the register file. There are no external data ports.

---
 rtl/mcu.sv | 202 ++++++++++++++++++++
 tb/tb_mcu.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcu.sv
// mcu: single-cycle RV32I core. Every rising edge retires one instruction
// fetched from rom[pc[7:2]]; results land in the register file (mem) and
// the word-organised data RAM (dmem) on that same edge.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous active-high; clears the PC only
// rom and mem are plain storage that is loaded hierarchically from outside.
module mcu (
  input logic clk,
  input logic reset
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  logic [31:0] rom  [0:63];
  logic [31:0] mem  [0:31];
  logic [31:0] dmem [0:63];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr;
  opcode_e     opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_y;
  logic        alu_alt;
  logic [7:0]  ls_addr;
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_we, rf_we;
  logic [31:0] rd_data, next_pc;

  assign instr  = rom[pc_q[7:2]];
  assign opcode = opcode_e'(instr[6:0]);
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign rs1_v = (rs1 == 5'd0) ? '0 : mem[rs1];
  assign rs2_v = (rs2 == 5'd0) ? '0 : mem[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Only the low 8 address bits reach the 64-word RAM, so the offset is
  // taken straight from the instruction at that width.
  always_comb begin
    if (opcode == OP_STORE) ls_addr = rs1_v[7:0] + {instr[27:25], instr[11:7]};
    else                    ls_addr = rs1_v[7:0] + instr[27:20];
  end

  // ALU operand select; alt means SUB for funct3=000 and SRA for funct3=101.
  always_comb begin
    alu_b   = rs2_v;
    alu_alt = 1'b0;
    if (opcode == OP_R) begin
      alu_alt = (instr[31:25] == 7'b0100000);
    end else begin
      alu_b   = imm_i;
      alu_alt = (funct3 == 3'b101) && instr[30];
    end
  end

  always_comb begin
    alu_y = '0;
    case (funct3)
      3'b000: alu_y = alu_alt ? (rs1_v - alu_b) : (rs1_v + alu_b);
      3'b001: alu_y = rs1_v << alu_b[4:0];
      3'b010: alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'b011: alu_y = {31'd0, rs1_v < alu_b};
      3'b100: alu_y = rs1_v ^ alu_b;
      3'b101: alu_y = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : (rs1_v >> alu_b[4:0]);
      3'b110: alu_y = rs1_v | alu_b;
      default: alu_y = rs1_v & alu_b;
    endcase
  end

  // Load path: halfword selection uses addr[1] only, so a misaligned
  // access stays inside the aligned word.
  always_comb begin
    ld_word = dmem[ls_addr[7:2]];
    ld_half = ls_addr[1] ? ld_word[31:16] : ld_word[15:0];
    case (ls_addr[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
  end

  // Store lanes: data is replicated across the word, the enables pick lanes.
  always_comb begin
    st_data = rs2_v;
    st_be   = 4'b1111;
    case (funct3)
      3'b000: begin
        st_data = {4{rs2_v[7:0]}};
        st_be   = 4'b0001 << ls_addr[1:0];
      end
      3'b001: begin
        st_data = {2{rs2_v[15:0]}};
        st_be   = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    rf_we   = 1'b0;
    st_we   = 1'b0;
    rd_data = '0;
    next_pc = pc_q + 32'd4;
    case (opcode)
      OP_R, OP_I: begin
        rf_we   = 1'b1;
        rd_data = alu_y;
      end
      OP_LOAD: begin
        rf_we = 1'b1;
        case (funct3)
          3'b000:  rd_data = {{24{ld_byte[7]}}, ld_byte};
          3'b001:  rd_data = {{16{ld_half[15]}}, ld_half};
          3'b010:  rd_data = ld_word;
          3'b100:  rd_data = {24'd0, ld_byte};
          3'b101:  rd_data = {16'd0, ld_half};
          default: rf_we = 1'b0;
        endcase
      end
      OP_STORE: st_we = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      OP_BRANCH: begin
        case (funct3)
          3'b000:  if (rs1_v == rs2_v) next_pc = pc_q + imm_b;
          3'b001:  if (rs1_v != rs2_v) next_pc = pc_q + imm_b;
          3'b100:  if ($signed(rs1_v) <  $signed(rs2_v)) next_pc = pc_q + imm_b;
          3'b101:  if ($signed(rs1_v) >= $signed(rs2_v)) next_pc = pc_q + imm_b;
          3'b110:  if (rs1_v <  rs2_v) next_pc = pc_q + imm_b;
          3'b111:  if (rs1_v >= rs2_v) next_pc = pc_q + imm_b;
          default: ;
        endcase
      end
      OP_LUI: begin
        rf_we   = 1'b1;
        rd_data = imm_u;
      end
      OP_AUIPC: begin
        rf_we   = 1'b1;
        rd_data = pc_q + imm_u;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        next_pc = pc_q + imm_j;
      end
      OP_JALR: begin
        rf_we   = 1'b1;
        rd_data = pc_q + 32'd4;
        next_pc = (rs1_v + imm_i) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
  end

  // The PC is kept inside the 64-word ROM window so it wraps with the fetch.
  assign pc_d = next_pc & 32'h0000_00FF;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  // Storage has no reset; an instruction in flight while reset is high
  // must not retire, hence the explicit gating.
  always_ff @(posedge clk) begin
    if (!reset && rf_we && (rd != 5'd0)) mem[rd] <= rd_data;
  end

  always_ff @(posedge clk) begin
    if (!reset && st_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_be[b]) dmem[ls_addr[7:2]][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mcu.sv
module tb_mcu;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  localparam logic [6:0] OPI = 7'h13, OPL = 7'h03, OPS = 7'h23, OPB = 7'h63;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;

  mcu dut (.clk(clk), .reset(reset));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPS};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPB};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Enter reset, then clear ROM and registers while nothing can retire.
  task automatic enter_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("pc_async_reset", dut.pc_q, 32'h0);
    for (int i = 0; i < 64; i++) dut.rom[i] = '0;
    for (int i = 0; i < 32; i++) dut.mem[i] = '0;
  endtask

  task automatic leave_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- R-type ----------------
    enter_reset();
    dut.mem[1] = 32'h0000_0001;
    dut.mem[2] = 32'h7FFF_FFFF;
    dut.mem[3] = 32'hFFFF_FFFF;
    dut.mem[4] = 32'h8000_0000;
    dut.mem[5] = 32'h0000_001F;
    dut.rom[0] = enc_r(7'h00, 5'd1, 5'd2, 3'b000, 5'd8);
    dut.rom[1] = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd9);
    dut.rom[2] = enc_r(7'h00, 5'd4, 5'd3, 3'b111, 5'd10);
    dut.rom[3] = enc_r(7'h00, 5'd3, 5'd4, 3'b110, 5'd11);
    dut.rom[4] = enc_r(7'h00, 5'd5, 5'd1, 3'b001, 5'd12);
    dut.rom[5] = enc_r(7'h00, 5'd5, 5'd4, 3'b101, 5'd13);
    dut.rom[6] = enc_r(7'h20, 5'd5, 5'd4, 3'b101, 5'd14);
    dut.rom[7] = enc_r(7'h00, 5'd2, 5'd4, 3'b010, 5'd15);
    dut.rom[8] = enc_r(7'h00, 5'd0, 5'd3, 3'b011, 5'd16);
    dut.rom[9] = enc_r(7'h00, 5'd4, 5'd3, 3'b100, 5'd17);
    leave_reset();
    chk("preload_survives_reset", dut.mem[2], 32'h7FFF_FFFF);
    chk("pc_after_release", dut.pc_q, 32'h0);
    run(10);
    chk("add",  dut.mem[8],  32'h8000_0000);
    chk("sub",  dut.mem[9],  32'h8000_0002);
    chk("and",  dut.mem[10], 32'h8000_0000);
    chk("or",   dut.mem[11], 32'hFFFF_FFFF);
    chk("sll",  dut.mem[12], 32'h8000_0000);
    chk("srl",  dut.mem[13], 32'h0000_0001);
    chk("sra",  dut.mem[14], 32'hFFFF_FFFF);
    chk("slt",  dut.mem[15], 32'h0000_0001);
    chk("sltu", dut.mem[16], 32'h0000_0000);
    chk("xor",  dut.mem[17], 32'h7FFF_FFFF);
    chk("pc_after_10", dut.pc_q, 32'd40);

    // ---------------- I-type and x0 ----------------
    enter_reset();
    dut.mem[1]  = 32'h0000_1010;
    dut.rom[0]  = enc_i(12'h001, 5'd1, 3'b000, 5'd3, OPI);
    dut.rom[1]  = enc_i(12'h001, 5'd1, 3'b111, 5'd4, OPI);
    dut.rom[2]  = enc_i(12'h001, 5'd1, 3'b110, 5'd5, OPI);
    dut.rom[3]  = enc_i(12'h001, 5'd1, 3'b010, 5'd6, OPI);
    dut.rom[4]  = enc_i(12'h001, 5'd1, 3'b011, 5'd7, OPI);
    dut.rom[5]  = enc_i(12'h001, 5'd1, 3'b100, 5'd8, OPI);
    dut.rom[6]  = enc_i(12'h001, 5'd1, 3'b001, 5'd9, OPI);
    dut.rom[7]  = enc_i(12'h001, 5'd1, 3'b101, 5'd10, OPI);
    dut.rom[8]  = enc_i(12'h401, 5'd1, 3'b101, 5'd11, OPI);
    dut.rom[9]  = enc_i(12'h005, 5'd0, 3'b000, 5'd0, OPI);
    dut.rom[10] = enc_i(12'h003, 5'd0, 3'b000, 5'd12, OPI);
    dut.rom[11] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd13, OPI);
    leave_reset();
    run(12);
    chk("addi",  dut.mem[3],  32'h0000_1011);
    chk("andi",  dut.mem[4],  32'h0000_0000);
    chk("ori",   dut.mem[5],  32'h0000_1011);
    chk("slti",  dut.mem[6],  32'h0000_0000);
    chk("sltiu", dut.mem[7],  32'h0000_0000);
    chk("xori",  dut.mem[8],  32'h0000_1011);
    chk("slli",  dut.mem[9],  32'h0000_2020);
    chk("srli",  dut.mem[10], 32'h0000_0808);
    chk("srai",  dut.mem[11], 32'h0000_0808);
    chk("x0_write_ignored", dut.mem[0], 32'h0);
    chk("x0_reads_zero", dut.mem[12], 32'h0000_0003);
    chk("addi_neg_imm", dut.mem[13], 32'h0000_100F);

    // ---------------- Store / load ----------------
    enter_reset();
    dut.mem[2]  = 32'h80FF_7F01;
    dut.rom[0]  = enc_s(12'd0, 5'd2, 5'd1, 3'b010);
    dut.rom[1]  = enc_i(12'd0, 5'd1, 3'b000, 5'd3, OPL);
    dut.rom[2]  = enc_i(12'd2, 5'd1, 3'b100, 5'd4, OPL);
    dut.rom[3]  = enc_i(12'd2, 5'd1, 3'b001, 5'd5, OPL);
    dut.rom[4]  = enc_i(12'd2, 5'd1, 3'b101, 5'd6, OPL);
    dut.rom[5]  = enc_i(12'd0, 5'd1, 3'b010, 5'd7, OPL);
    dut.rom[6]  = enc_i(12'd3, 5'd1, 3'b000, 5'd8, OPL);
    dut.rom[7]  = enc_s(12'd4, 5'd2, 5'd1, 3'b010);
    dut.rom[8]  = enc_s(12'd5, 5'd0, 5'd1, 3'b000);
    dut.rom[9]  = enc_i(12'd4, 5'd1, 3'b010, 5'd9, OPL);
    dut.rom[10] = enc_s(12'd6, 5'd3, 5'd1, 3'b001);
    dut.rom[11] = enc_i(12'd4, 5'd1, 3'b010, 5'd10, OPL);
    leave_reset();
    run(12);
    chk("lb_0",   dut.mem[3],  32'h0000_0001);
    chk("lbu_2",  dut.mem[4],  32'h0000_00FF);
    chk("lh_2",   dut.mem[5],  32'hFFFF_80FF);
    chk("lhu_2",  dut.mem[6],  32'h0000_80FF);
    chk("lw_0",   dut.mem[7],  32'h80FF_7F01);
    chk("lb_3",   dut.mem[8],  32'hFFFF_FF80);
    chk("sb_lane", dut.mem[9], 32'h80FF_0001);
    chk("sh_lane", dut.mem[10], 32'h0001_0001);
    chk("store_no_rd", dut.mem[0], 32'h0);

    // ---------------- Branch / jump ----------------
    enter_reset();
    dut.rom[0]  = enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI);
    dut.rom[1]  = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    dut.rom[2]  = enc_i(12'd9, 5'd0, 3'b000, 5'd2, OPI);
    dut.rom[3]  = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    dut.rom[4]  = enc_i(12'd7, 5'd0, 3'b000, 5'd3, OPI);
    dut.rom[5]  = enc_j(21'd8, 5'd4);
    dut.rom[6]  = enc_i(12'd9, 5'd0, 3'b000, 5'd5, OPI);
    dut.rom[7]  = enc_i(12'h051, 5'd0, 3'b000, 5'd6, OPI);
    dut.rom[8]  = enc_i(12'd0, 5'd6, 3'b000, 5'd7, JALR);
    dut.rom[9]  = enc_i(12'd9, 5'd0, 3'b000, 5'd13, OPI);
    dut.rom[20] = enc_u(20'h00000, 5'd8, AUIPC);
    dut.rom[21] = enc_u(20'h80000, 5'd9, LUI);
    dut.rom[22] = enc_b(13'd8, 5'd1, 5'd9, 3'b100);
    dut.rom[23] = enc_i(12'd9, 5'd0, 3'b000, 5'd11, OPI);
    dut.rom[24] = enc_b(13'd8, 5'd1, 5'd9, 3'b110);
    dut.rom[25] = enc_i(12'd5, 5'd0, 3'b000, 5'd12, OPI);
    leave_reset();
    run(12);
    chk("beq_taken_skips", dut.mem[2], 32'h0);
    chk("bne_fallthrough", dut.mem[3], 32'd7);
    chk("jal_link", dut.mem[4], 32'd24);
    chk("jal_skips", dut.mem[5], 32'h0);
    chk("jalr_link", dut.mem[7], 32'd36);
    chk("jalr_skips", dut.mem[13], 32'h0);
    chk("jalr_bit0_clear", dut.mem[8], 32'h0000_0050);
    chk("lui", dut.mem[9], 32'h8000_0000);
    chk("blt_signed_taken", dut.mem[11], 32'h0);
    chk("bltu_not_taken", dut.mem[12], 32'd5);
    chk("pc_after_branches", dut.pc_q, 32'd104);

    // ---------------- NOP tail and PC wrap ----------------
    enter_reset();
    dut.mem[5] = 32'h1234_5678;
    dut.rom[0] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI);
    leave_reset();
    run(64);
    chk("nop_tail_x1", dut.mem[1], 32'd1);
    chk("nop_tail_x5", dut.mem[5], 32'h1234_5678);
    chk("nop_tail_x0", dut.mem[0], 32'h0);
    chk("pc_wrapped", dut.pc_q, 32'h0);
    run(1);
    chk("wrap_reexec", dut.mem[1], 32'd2);

    // ---------------- Reset mid-program ----------------
    enter_reset();
    dut.rom[0] = enc_i(12'd1, 5'd1, 3'b000, 5'd1, OPI);
    dut.rom[1] = enc_i(12'd1, 5'd2, 3'b000, 5'd2, OPI);
    dut.rom[2] = enc_i(12'd1, 5'd3, 3'b000, 5'd3, OPI);
    leave_reset();
    run(2);
    chk("mid_x1_before", dut.mem[1], 32'd1);
    chk("mid_pc_before", dut.pc_q, 32'd8);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_pc_async", dut.pc_q, 32'h0);
    leave_reset();
    chk("mid_no_retire", dut.mem[1], 32'd1);
    chk("mid_x3_kept", dut.mem[3], 32'd0);
    run(3);
    chk("mid_restart_x1", dut.mem[1], 32'd2);
    chk("mid_restart_x2", dut.mem[2], 32'd2);
    chk("mid_restart_x3", dut.mem[3], 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
